// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: register index, machine word and the
// pipeline-control FSM state encoding.
package lc3b_types;

  typedef logic [2:0]  lc3b_reg;
  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_STALL = 2'd1,
    BUBBLE    = 2'd2
  } pipe_ctrl_state_t;

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// Load-use comparator: flags an IF/ID source register that the load in ID/EX
// has not produced yet.
module hazard_detect
  import lc3b_types::*;
(
  input  logic    ex_is_load,
  input  lc3b_reg ex_dest,
  input  lc3b_reg id_sr1,
  input  lc3b_reg id_sr2,
  input  logic    id_use_sr1,
  input  logic    id_use_sr2,
  output logic    load_use
);

  assign load_use = ex_is_load &
                    ((id_use_sr1 & (id_sr1 == ex_dest)) |
                     (id_use_sr2 & (id_sr2 == ex_dest)));

endmodule

// File: rtl/pipeline_control.sv
// Pipeline latch-enable / squash generation for the LC-3b 5-stage pipeline,
// with a RUN/MEM_STALL/BUBBLE tracking FSM and saturating performance counters.
module pipeline_control
  import lc3b_types::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  input  logic             ex_is_load,
  input  lc3b_reg          ex_dest,
  input  lc3b_reg          id_sr1,
  input  lc3b_reg          id_sr2,
  input  logic             id_use_sr1,
  input  logic             id_use_sr2,
  input  logic             mem_br_taken,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             squash_if_id,
  output logic             squash_id_ex,
  output logic             squash_ex_mem,
  output lc3b_word         stall_cycles,
  output lc3b_word         bubble_count,
  output lc3b_word         flush_count,
  output pipe_ctrl_state_t ctrl_state
);

  function automatic lc3b_word sat_inc(input lc3b_word c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic imem_stall, dmem_stall, advance;
  logic hd_load_use, load_use, do_flush, do_bubble;

  hazard_detect u_hazard_detect (
    .ex_is_load (ex_is_load),
    .ex_dest    (ex_dest),
    .id_sr1     (id_sr1),
    .id_sr2     (id_sr2),
    .id_use_sr1 (id_use_sr1),
    .id_use_sr2 (id_use_sr2),
    .load_use   (hd_load_use)
  );

  assign imem_stall = imem_read & ~imem_resp;
  assign dmem_stall = (dmem_read | dmem_write) & ~dmem_resp;
  assign advance    = ~imem_stall & ~dmem_stall;

  // ID/EX already holds the inserted NOP while in BUBBLE, so the stale
  // comparison must not trigger a second bubble.
  assign load_use  = hd_load_use & (ctrl_state != BUBBLE);
  assign do_flush  = advance & mem_br_taken;
  assign do_bubble = advance & ~mem_br_taken & load_use;

  always_comb begin
    load_pc       = 1'b0;
    load_if_id    = 1'b0;
    load_id_ex    = 1'b0;
    load_ex_mem   = 1'b0;
    load_mem_wb   = 1'b0;
    squash_if_id  = 1'b0;
    squash_id_ex  = 1'b0;
    squash_ex_mem = 1'b0;
    if (!rst_n) begin
      {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b11111;
      {squash_if_id, squash_id_ex, squash_ex_mem}                 = 3'b111;
    end else if (!advance) begin
      // frozen: every latch holds
    end else if (do_flush) begin
      {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b11111;
      {squash_if_id, squash_id_ex, squash_ex_mem}                 = 3'b111;
    end else if (do_bubble) begin
      {load_id_ex, load_ex_mem, load_mem_wb} = 3'b111;
      squash_id_ex = 1'b1;
    end else begin
      {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b11111;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_state   <= RUN;
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (!advance)       ctrl_state <= MEM_STALL;
      else if (do_bubble) ctrl_state <= BUBBLE;
      else                ctrl_state <= RUN;
      if (!advance) stall_cycles <= sat_inc(stall_cycles);
      if (do_bubble) bubble_count <= sat_inc(bubble_count);
      if (do_flush)  flush_count  <= sat_inc(flush_count);
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed-vector bench for pipeline_control: enables, squashes, FSM state
// and counters against hand-computed values.
module tb_pipeline_control;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst_n;
  logic imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
  logic ex_is_load, id_use_sr1, id_use_sr2, mem_br_taken;
  lc3b_reg ex_dest, id_sr1, id_sr2;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic squash_if_id, squash_id_ex, squash_ex_mem;
  lc3b_word stall_cycles, bubble_count, flush_count;
  pipe_ctrl_state_t ctrl_state;

  logic [4:0] loads;
  logic [2:0] sq;
  assign loads = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
  assign sq    = {squash_if_id, squash_id_ex, squash_ex_mem};

  int n_cmp = 0;
  int n_fail = 0;
  int exp_stall = 0, exp_bubble = 0, exp_flush = 0;

  always #5 clk = ~clk;

  pipeline_control dut (
    .clk(clk), .rst_n(rst_n),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_use_sr1(id_use_sr1), .id_use_sr2(id_use_sr2),
    .mem_br_taken(mem_br_taken),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .squash_if_id(squash_if_id), .squash_id_ex(squash_id_ex),
    .squash_ex_mem(squash_ex_mem),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count),
    .flush_count(flush_count), .ctrl_state(ctrl_state)
  );

  task automatic idle_inputs();
    imem_read = 1'b1; imem_resp = 1'b1;
    dmem_read = 1'b0; dmem_write = 1'b0; dmem_resp = 1'b0;
    ex_is_load = 1'b0; ex_dest = 3'd0; id_sr1 = 3'd0; id_sr2 = 3'd0;
    id_use_sr1 = 1'b0; id_use_sr2 = 1'b0; mem_br_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    n_cmp++; if (loads !== 5'b11111) begin n_fail++; $display("FAIL reset_loads got=%b exp=11111", loads); end
    n_cmp++; if (sq !== 3'b111) begin n_fail++; $display("FAIL reset_squash got=%b exp=111", sq); end
    n_cmp++; if (ctrl_state !== RUN) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", ctrl_state, RUN); end
    n_cmp++; if ({stall_cycles, bubble_count, flush_count} !== 48'd0) begin n_fail++; $display("FAIL reset_counters got=%h/%h/%h exp=0/0/0", stall_cycles, bubble_count, flush_count); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_no_hazard();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++; if (loads !== 5'b11111 || sq !== 3'b000) begin n_fail++; $display("FAIL nohaz_outs cyc=%0d got=%b/%b exp=11111/000", i, loads, sq); end
      tick();
    end
    n_cmp++; if ({stall_cycles, bubble_count, flush_count} !== 48'd0 || ctrl_state !== RUN) begin n_fail++; $display("FAIL nohaz_counters got=%h/%h/%h st=%0d exp=0/0/0 st=0", stall_cycles, bubble_count, flush_count, ctrl_state); end
  endtask

  task automatic test_imem_stall();
    idle_inputs();
    imem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (loads !== 5'b00000 || sq !== 3'b000) begin n_fail++; $display("FAIL istall_outs cyc=%0d got=%b/%b exp=00000/000", i, loads, sq); end
      tick();
      n_cmp++; if (ctrl_state !== MEM_STALL) begin n_fail++; $display("FAIL istall_state cyc=%0d got=%0d exp=%0d", i, ctrl_state, MEM_STALL); end
    end
    exp_stall += 3;
    imem_resp = 1'b1;
    #1;
    n_cmp++; if (loads !== 5'b11111) begin n_fail++; $display("FAIL istall_release got=%b exp=11111", loads); end
    tick();
    n_cmp++; if (stall_cycles !== 16'(exp_stall) || ctrl_state !== RUN) begin n_fail++; $display("FAIL istall_count got=%0d st=%0d exp=%0d st=0", stall_cycles, ctrl_state, exp_stall); end
  endtask

  task automatic test_load_use();
    idle_inputs();
    ex_is_load = 1'b1; ex_dest = 3'd3; id_sr1 = 3'd3; id_use_sr1 = 1'b1;
    #1;
    n_cmp++; if (loads !== 5'b00111 || sq !== 3'b010) begin n_fail++; $display("FAIL lu_outs got=%b/%b exp=00111/010", loads, sq); end
    tick();
    exp_bubble++;
    n_cmp++; if (bubble_count !== 16'(exp_bubble) || ctrl_state !== BUBBLE) begin n_fail++; $display("FAIL lu_count got=%0d st=%0d exp=%0d st=2", bubble_count, ctrl_state, exp_bubble); end
    // same hazard inputs held: no second bubble
    n_cmp++; if (loads !== 5'b11111 || sq !== 3'b000) begin n_fail++; $display("FAIL lu_second got=%b/%b exp=11111/000", loads, sq); end
    tick();
    n_cmp++; if (bubble_count !== 16'(exp_bubble) || ctrl_state !== RUN) begin n_fail++; $display("FAIL lu_once got=%0d st=%0d exp=%0d st=0", bubble_count, ctrl_state, exp_bubble); end
    // matching sr1 but not used: no hazard
    id_sr1 = 3'd5; ex_dest = 3'd5; id_use_sr1 = 1'b0;
    #1;
    n_cmp++; if (loads !== 5'b11111 || sq !== 3'b000) begin n_fail++; $display("FAIL lu_unused got=%b/%b exp=11111/000", loads, sq); end
    // hazard through sr2
    id_sr2 = 3'd5; id_use_sr2 = 1'b1; id_sr1 = 3'd1;
    #1;
    n_cmp++; if (loads !== 5'b00111 || sq !== 3'b010) begin n_fail++; $display("FAIL lu_sr2 got=%b/%b exp=00111/010", loads, sq); end
    tick();
    exp_bubble++;
    idle_inputs();
    tick();
    n_cmp++; if (bubble_count !== 16'(exp_bubble)) begin n_fail++; $display("FAIL lu_sr2_count got=%0d exp=%0d", bubble_count, exp_bubble); end
  endtask

  task automatic test_flush();
    idle_inputs();
    ex_is_load = 1'b1; ex_dest = 3'd2; id_sr1 = 3'd2; id_use_sr1 = 1'b1;
    mem_br_taken = 1'b1;
    #1;
    n_cmp++; if (loads !== 5'b11111 || sq !== 3'b111) begin n_fail++; $display("FAIL flush_outs got=%b/%b exp=11111/111", loads, sq); end
    tick();
    exp_flush++;
    n_cmp++; if (flush_count !== 16'(exp_flush) || bubble_count !== 16'(exp_bubble) || ctrl_state !== RUN) begin n_fail++; $display("FAIL flush_count got=%0d/%0d st=%0d exp=%0d/%0d st=0", flush_count, bubble_count, ctrl_state, exp_flush, exp_bubble); end
    idle_inputs();
  endtask

  task automatic test_flush_during_stall();
    idle_inputs();
    dmem_read = 1'b1; dmem_resp = 1'b0; mem_br_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (loads !== 5'b00000 || sq !== 3'b000) begin n_fail++; $display("FAIL bstall_outs cyc=%0d got=%b/%b exp=00000/000", i, loads, sq); end
      tick();
    end
    exp_stall += 2;
    n_cmp++; if (flush_count !== 16'(exp_flush)) begin n_fail++; $display("FAIL bstall_noflush got=%0d exp=%0d", flush_count, exp_flush); end
    dmem_resp = 1'b1;
    #1;
    n_cmp++; if (loads !== 5'b11111 || sq !== 3'b111) begin n_fail++; $display("FAIL bstall_flush got=%b/%b exp=11111/111", loads, sq); end
    tick();
    exp_flush++;
    idle_inputs();
    #1;
    n_cmp++; if (sq !== 3'b000) begin n_fail++; $display("FAIL bstall_after got=%b exp=000", sq); end
    n_cmp++; if (flush_count !== 16'(exp_flush) || stall_cycles !== 16'(exp_stall)) begin n_fail++; $display("FAIL bstall_counts got=%0d/%0d exp=%0d/%0d", flush_count, stall_cycles, exp_flush, exp_stall); end
  endtask

  task automatic test_double_stall();
    idle_inputs();
    imem_resp = 1'b0; dmem_write = 1'b1; dmem_resp = 1'b0;
    tick();
    exp_stall++;
    idle_inputs();
    n_cmp++; if (stall_cycles !== 16'(exp_stall) || ctrl_state !== MEM_STALL) begin n_fail++; $display("FAIL dstall_count got=%0d st=%0d exp=%0d st=1", stall_cycles, ctrl_state, exp_stall); end
    tick();
  endtask

  task automatic test_reset_mid_bubble();
    idle_inputs();
    ex_is_load = 1'b1; ex_dest = 3'd4; id_sr2 = 3'd4; id_use_sr2 = 1'b1;
    tick();
    n_cmp++; if (ctrl_state !== BUBBLE) begin n_fail++; $display("FAIL rmid_enter got=%0d exp=%0d", ctrl_state, BUBBLE); end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ctrl_state !== RUN || {stall_cycles, bubble_count, flush_count} !== 48'd0) begin n_fail++; $display("FAIL rmid_async st=%0d cnt=%h/%h/%h exp st=0 cnt=0", ctrl_state, stall_cycles, bubble_count, flush_count); end
    tick();
    rst_n = 1'b1;
    exp_stall = 0; exp_bubble = 0; exp_flush = 0;
    tick();
    n_cmp++; if (ctrl_state !== RUN || loads !== 5'b11111 || sq !== 3'b000) begin n_fail++; $display("FAIL rmid_after st=%0d got=%b/%b exp st=0 11111/000", ctrl_state, loads, sq); end
  endtask

  task automatic test_saturation();
    idle_inputs();
    imem_resp = 1'b0;
    for (int i = 0; i < 65535; i++) tick();
    n_cmp++; if (stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_preload got=%h exp=ffff", stall_cycles); end
    tick(); tick();
    n_cmp++; if (stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", stall_cycles); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (stall_cycles !== 16'h0000) begin n_fail++; $display("FAIL sat_reset got=%h exp=0000", stall_cycles); end
    tick();
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_no_hazard();
    test_imem_stall();
    test_load_use();
    test_flush();
    test_flush_during_stall();
    test_double_stall();
    test_reset_mid_bubble();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
